// File: rtl/mem_dp_pkg.sv
// mem_dp_pkg: shared state type, latency limits and default sizes for mem_dp_param
package mem_dp_pkg;
  typedef enum logic {INIT, READY} state_t;
  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 2;
  localparam int DATA_W_DEF = 8;
  localparam int DEPTH_DEF  = 32;
endpackage

// File: rtl/mem_rd_pipe.sv
// mem_rd_pipe: RD_LAT-stage read data/valid delay line; data holds between valid pulses
module mem_rd_pipe #(
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data
);
  logic [RD_LAT-1:0] r_vld;
  logic [DATA_W-1:0] r_dat [RD_LAT];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_vld <= '0;
      for (int k = 0; k < RD_LAT; k++) r_dat[k] <= '0;
    end else begin
      r_vld[0] <= i_valid;
      if (i_valid) r_dat[0] <= i_data;
      for (int k = 1; k < RD_LAT; k++) begin
        r_vld[k] <= r_vld[k-1];
        if (r_vld[k-1]) r_dat[k] <= r_dat[k-1];
      end
    end
  assign o_valid = r_vld[RD_LAT-1];
  assign o_data  = r_dat[RD_LAT-1];
endmodule

// File: rtl/mem_dp_param.sv
// mem_dp_param: dual-port RAM with init clear, collision/err flags and pipelined reads.
// Define MEM_WR_BYPASS_EN to forward same-cycle write data to a same-address read.
module mem_dp_param
  import mem_dp_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int RD_LAT = RD_LAT_MIN,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              p0_read,
  input  logic              p0_write,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_data_in,
  output logic [DATA_W-1:0] p0_data_out,
  output logic              p0_valid,
  input  logic              p1_read,
  input  logic              p1_write,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_data_in,
  output logic [DATA_W-1:0] p1_data_out,
  output logic              p1_valid,
  output logic              busy,
  output logic              collision,
  output logic              err
);
  state_t            r_state, w_state_nx;
  logic [ADDR_W-1:0] r_init_cnt;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic              r_collision, r_err;
  logic              w_ready, w_wr0, w_wr1, w_rd0, w_rd1, w_coll, w_bad;
  logic [DATA_W-1:0] w_rdata0, w_rdata1;
  assign w_ready = r_state == READY;
  assign w_wr0   = w_ready && p0_write && !p0_read;
  assign w_wr1   = w_ready && p1_write && !p1_read;
  assign w_rd0   = w_ready && p0_read && !p0_write;
  assign w_rd1   = w_ready && p1_read && !p1_write;
  assign w_coll  = w_wr0 && w_wr1 && p0_addr == p1_addr;
  assign w_bad   = w_ready && ((p0_read && p0_write) || (p1_read && p1_write));
  always_comb w_state_nx = (r_state == INIT && r_init_cnt == ADDR_W'(DEPTH - 1)) ? READY : r_state;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state     <= INIT;
      r_init_cnt  <= '0;
      r_collision <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      if (r_state == INIT) r_init_cnt <= r_init_cnt + 1'b1;
      r_collision <= w_coll;
      r_err       <= r_err | w_bad;
    end
  // port 0 is written last so it wins a same-address collision
  always_ff @(posedge clk)
    if (r_state == INIT) r_mem[r_init_cnt] <= '0;
    else begin
      if (w_wr1) r_mem[p1_addr] <= p1_data_in;
      if (w_wr0) r_mem[p0_addr] <= p0_data_in;
    end
`ifdef MEM_WR_BYPASS_EN
  assign w_rdata0 = (w_wr1 && p1_addr == p0_addr) ? p1_data_in : r_mem[p0_addr];
  assign w_rdata1 = (w_wr0 && p0_addr == p1_addr) ? p0_data_in : r_mem[p1_addr];
`else
  assign w_rdata0 = r_mem[p0_addr];
  assign w_rdata1 = r_mem[p1_addr];
`endif
  mem_rd_pipe #(.DATA_W(DATA_W), .RD_LAT(RD_LAT)) u_pipe0 (
    .clk(clk), .rst_n(rst_n), .i_valid(w_rd0), .i_data(w_rdata0),
    .o_valid(p0_valid), .o_data(p0_data_out)
  );
  mem_rd_pipe #(.DATA_W(DATA_W), .RD_LAT(RD_LAT)) u_pipe1 (
    .clk(clk), .rst_n(rst_n), .i_valid(w_rd1), .i_data(w_rdata1),
    .o_valid(p1_valid), .o_data(p1_data_out)
  );
  assign busy      = r_state == INIT;
  assign collision = r_collision;
  assign err       = r_err;
endmodule

// File: tb/tb_mem_dp_param.sv
// tb_mem_dp_param: directed and randomized checks of mem_dp_param at RD_LAT 1 and 2
module tb_mem_dp_param;
  localparam int DEPTH = 32;
  logic clk = 1'b0;
  logic rst_n;
  logic p0_read, p0_write, p1_read, p1_write;
  logic [4:0] p0_addr, p1_addr;
  logic [7:0] p0_data_in, p1_data_in;
  logic [1:0] v1, v2;
  logic [7:0] d1 [2];
  logic [7:0] d2 [2];
  logic bz1, bz2, c1, c2, e1, e2;
  int checks = 0, errors = 0;
  logic [7:0] mm [DEPTH];
  int n = 0, busy_left = DEPTH;
  logic hv [2][4096];
  logic [7:0] hd [2][4096];
  logic ev [2][2];
  logic [7:0] ed [2][2];
  logic e_coll, e_err;

  always #5 clk = ~clk;

  mem_dp_param #(.DATA_W(8), .DEPTH(DEPTH), .RD_LAT(1)) u_lat1 (
    .clk(clk), .rst_n(rst_n),
    .p0_read(p0_read), .p0_write(p0_write), .p0_addr(p0_addr), .p0_data_in(p0_data_in),
    .p0_data_out(d1[0]), .p0_valid(v1[0]),
    .p1_read(p1_read), .p1_write(p1_write), .p1_addr(p1_addr), .p1_data_in(p1_data_in),
    .p1_data_out(d1[1]), .p1_valid(v1[1]),
    .busy(bz1), .collision(c1), .err(e1)
  );
  mem_dp_param #(.DATA_W(8), .DEPTH(DEPTH), .RD_LAT(2)) u_lat2 (
    .clk(clk), .rst_n(rst_n),
    .p0_read(p0_read), .p0_write(p0_write), .p0_addr(p0_addr), .p0_data_in(p0_data_in),
    .p0_data_out(d2[0]), .p0_valid(v2[0]),
    .p1_read(p1_read), .p1_write(p1_write), .p1_addr(p1_addr), .p1_data_in(p1_data_in),
    .p1_data_out(d2[1]), .p1_valid(v2[1]),
    .busy(bz2), .collision(c2), .err(e2)
  );

  task automatic idle();
    p0_read = 0; p0_write = 0; p1_read = 0; p1_write = 0;
  endtask

  // reference model: reads see the memory before this cycle's writes, or after them with bypass
  task automatic tick();
    logic w0, w1, r0, r1;
    logic [7:0] nm [DEPTH];
    @(posedge clk);
    n++;
    hv[0][n] = 0; hv[1][n] = 0; e_coll = 0;
    if (!rst_n) busy_left = DEPTH;
    else if (busy_left > 0) begin
      busy_left--;
      if (busy_left == 0) foreach (mm[i]) mm[i] = 8'h00;
    end else begin
      w0 = p0_write && !p0_read; w1 = p1_write && !p1_read;
      r0 = p0_read && !p0_write; r1 = p1_read && !p1_write;
      if ((p0_read && p0_write) || (p1_read && p1_write)) e_err = 1;
      nm = mm;
      if (w1) nm[p1_addr] = p1_data_in;
      if (w0) nm[p0_addr] = p0_data_in;
      hv[0][n] = r0; hv[1][n] = r1;
`ifdef MEM_WR_BYPASS_EN
      hd[0][n] = nm[p0_addr]; hd[1][n] = nm[p1_addr];
`else
      hd[0][n] = mm[p0_addr]; hd[1][n] = mm[p1_addr];
`endif
      e_coll = w0 && w1 && p0_addr == p1_addr;
      mm = nm;
    end
    for (int l = 0; l < 2; l++)
      for (int p = 0; p < 2; p++) begin
        ev[l][p] = (n - l >= 1) && hv[p][n-l];
        if (ev[l][p]) ed[l][p] = hd[p][n-l];
      end
    #1;
  endtask

  task automatic assert_reset();
    rst_n = 0;
    for (int i = 0; i < 4096; i++) begin hv[0][i] = 0; hv[1][i] = 0; end
    for (int l = 0; l < 2; l++)
      for (int p = 0; p < 2; p++) begin ev[l][p] = 0; ed[l][p] = 8'h00; end
    e_coll = 0; e_err = 0; busy_left = DEPTH;
    #1;
  endtask

  task automatic test_reset();
    idle(); p0_addr = 0; p1_addr = 0; p0_data_in = 0; p1_data_in = 0;
    assert_reset();
    checks++;
    if ({v1, v2, d1[0], d1[1], d2[0], d2[1], c1, c2, e1, e2, bz1, bz2} !== {38'd0, 2'b11}) begin
      errors++;
      $display("FAIL reset_state got v1=%b v2=%b d1=%h/%h d2=%h/%h col=%b%b err=%b%b busy=%b%b want zeros busy=11",
               v1, v2, d1[0], d1[1], d2[0], d2[1], c1, c2, e1, e2, bz1, bz2);
    end
    tick(); tick();
  endtask

  // busy must stay high exactly DEPTH cycles with no valid, then a held read returns 0
  task automatic busy_window(input string tag);
    int cnt = 0;
    int bad = 0;
    while (bz1 && cnt < DEPTH + 8) begin
      if (v1 != 0 || v2 != 0 || e1 || e2 || bz2 !== bz1) bad++;
      tick(); cnt++;
    end
    checks++;
    if (cnt != DEPTH || bad != 0) begin
      errors++;
      $display("FAIL %s_busy got cycles=%0d stray=%0d want cycles=%0d stray=0", tag, cnt, bad, DEPTH);
    end
  endtask

  task automatic test_init();
    rst_n = 1;
    p0_read = 1; p0_addr = 0;
    busy_window("init");
    tick();
    checks++;
    if (v1[0] !== 1 || d1[0] !== 8'h00 || v2[0] !== 0) begin
      errors++;
      $display("FAIL init_read_lat1 got v1=%b d=%h v2=%b want 1 00 0", v1[0], d1[0], v2[0]);
    end
    idle(); tick();
    checks++;
    if (v2[0] !== 1 || d2[0] !== 8'h00 || v1[0] !== 0) begin
      errors++;
      $display("FAIL init_read_lat2 got v2=%b d=%h v1=%b want 1 00 0", v2[0], d2[0], v1[0]);
    end
  endtask

  task automatic test_write_read();
    idle(); p0_write = 1; p0_addr = 3; p0_data_in = 8'hA5; tick();
    idle(); p1_read = 1; p1_addr = 3; tick();
    checks++;
    if (v1[1] !== 1 || d1[1] !== 8'hA5 || v2[1] !== 0) begin
      errors++;
      $display("FAIL wr_rd_lat1 got v=%b d=%h v2=%b want 1 a5 0", v1[1], d1[1], v2[1]);
    end
    idle(); tick();
    checks++;
    if (v2[1] !== 1 || d2[1] !== 8'hA5 || v1[1] !== 0 || d1[1] !== 8'hA5) begin
      errors++;
      $display("FAIL wr_rd_lat2 got v2=%b d2=%h v1=%b d1=%h want 1 a5 0 a5", v2[1], d2[1], v1[1], d1[1]);
    end
  endtask

  task automatic test_collision();
    idle(); p0_write = 1; p1_write = 1; p0_addr = 7; p1_addr = 7;
    p0_data_in = 8'h11; p1_data_in = 8'h22; tick();
    checks++;
    if (c1 !== 1 || c2 !== 1) begin
      errors++; $display("FAIL coll_pulse got %b%b want 11", c1, c2);
    end
    idle(); p1_read = 1; tick();
    checks++;
    if (c1 !== 0 || c2 !== 0) begin
      errors++; $display("FAIL coll_width got %b%b want 00", c1, c2);
    end
    idle(); tick();
    checks++;
    if (d1[1] !== 8'h11 || v2[1] !== 1 || d2[1] !== 8'h11) begin
      errors++; $display("FAIL coll_data got d1=%h v2=%b d2=%h want 11 1 11", d1[1], v2[1], d2[1]);
    end
  endtask

  task automatic test_rw_same();
    logic [7:0] want;
`ifdef MEM_WR_BYPASS_EN
    want = 8'h3C;
`else
    want = 8'h00;
`endif
    idle(); p0_write = 1; p0_addr = 5; p0_data_in = 8'h3C; p1_read = 1; p1_addr = 5; tick();
    checks++;
    if (v1[1] !== 1 || d1[1] !== want) begin
      errors++; $display("FAIL rw_same_lat1 got v=%b d=%h want 1 %h", v1[1], d1[1], want);
    end
    idle(); p1_read = 1; tick();
    checks++;
    if (v2[1] !== 1 || d2[1] !== want || d1[1] !== 8'h3C) begin
      errors++; $display("FAIL rw_same_lat2 got d2=%h d1_next=%h want %h 3c", d2[1], d1[1], want);
    end
    idle(); tick();
  endtask

  task automatic test_err();
    idle(); p1_read = 1; p1_write = 1; p1_addr = 9; p1_data_in = 8'hFF; tick();
    idle(); p0_read = 1; p0_addr = 9;
    checks++;
    if (e1 !== 1 || e2 !== 1 || v1[1] !== 0) begin
      errors++; $display("FAIL err_set got err=%b%b v=%b want 11 0", e1, e2, v1[1]);
    end
    tick();
    idle(); tick();
    checks++;
    if (e1 !== 1 || v2[1] !== 0 || d2[0] !== 8'h00 || v2[0] !== 1) begin
      errors++; $display("FAIL err_sticky got err=%b v2p1=%b d2p0=%h want 1 0 00", e1, v2[1], d2[0]);
    end
    p0_read = 1; p0_addr = 3; tick();
    assert_reset();
    checks++;
    if (e1 !== 0 || e2 !== 0 || v1 !== 0 || d1[0] !== 0 || d2[0] !== 0 || bz1 !== 1 || bz2 !== 1) begin
      errors++; $display("FAIL err_clear got err=%b%b v1=%b d1=%h busy=%b want 00 00 00 1", e1, e2, v1, d1[0], bz1);
    end
    tick();
  endtask

  task automatic test_reset_mid_init();
    idle(); rst_n = 1; p0_read = 1; p0_addr = 3;
    for (int i = 0; i < 10; i++) tick();
    assert_reset();
    tick();
    rst_n = 1;
    busy_window("mid_init");
    tick();
    checks++;
    if (v1[0] !== 1 || d1[0] !== 8'h00) begin
      errors++; $display("FAIL mid_init_cleared got v=%b d=%h want 1 00", v1[0], d1[0]);
    end
    idle(); tick();
  endtask

  task automatic test_random();
    logic [41:0] obs, want;
    int op;
    int bad = 0;
    for (int c = 0; c < 500; c++) begin
      op = $urandom_range(0, 39);
      p0_read = op < 16 || op == 39; p0_write = (op >= 16 && op < 34) || op == 39;
      op = $urandom_range(0, 39);
      p1_read = op < 16 || op == 39; p1_write = (op >= 16 && op < 34) || op == 39;
      p0_addr = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 3));
      p1_addr = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 3));
      p0_data_in = 8'($urandom); p1_data_in = 8'($urandom);
      tick();
      obs  = {v1, d1[0], d1[1], v2, d2[0], d2[1], bz1, bz2, c1, c2, e1, e2};
      want = {ev[0][1], ev[0][0], ed[0][0], ed[0][1], ev[1][1], ev[1][0], ed[1][0], ed[1][1],
              busy_left > 0, busy_left > 0, e_coll, e_coll, e_err, e_err};
      checks++;
      if (obs !== want) begin
        errors++; bad++;
        if (bad <= 10) $display("FAIL random_cycle%0d got %h want %h", c, obs, want);
      end
    end
    idle(); tick();
  endtask

  initial begin
    test_reset();
    test_init();
    test_write_read();
    test_collision();
    test_rw_same();
    test_err();
    test_reset_mid_init();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_dp_param.md
MEM_DP_PARAM -- requirements
Module: mem_dp_param

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL have parameter DATA_W, default 8, giving the word width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 32, giving the number of words; legal values are powers of two from 4 to 1024.
REQ-003 The block SHALL have parameter RD_LAT, default 1, giving read latency in cycles; legal values are 1 and 2.
REQ-004 The block SHALL derive localparam ADDR_W as $clog2(DEPTH).

Ports (name, direction, width, meaning):
REQ-005 clk  input  1  single clock; all state changes on posedge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 pN_read  input  1  read request on port N, where N is 0 or 1.
REQ-008 pN_write  input  1  write request on port N.
REQ-009 pN_addr  input  ADDR_W  address for port N.
REQ-010 pN_data_in  input  DATA_W  write data for port N.
REQ-011 pN_data_out  output  DATA_W  read data for port N.
REQ-012 pN_valid  output  1  one-cycle pulse marking pN_data_out as valid.
REQ-013 busy  output  1  high while init clear runs; all requests are ignored while busy is high.
REQ-014 collision  output  1  one-cycle pulse flagging a same-address write/write collision.
REQ-015 err  output  1  sticky flag for an illegal request; cleared only by reset.

Function
REQ-016 The FSM SHALL have two states, INIT and READY; INIT is entered on reset.
REQ-017 In INIT, the FSM SHALL write 0 to one word per cycle, from address 0 to address DEPTH-1, with busy high.
REQ-018 In INIT, after the DEPTH-1 write, the FSM SHALL move to READY and drop busy, so busy stays high for exactly DEPTH cycles after reset release.
REQ-019 In READY, a write SHALL occur when pN_write=1 and pN_read=0: memory[pN_addr] gets pN_data_in at that posedge.
REQ-020 In READY, a read SHALL occur when pN_read=1 and pN_write=0; pN_data_out and pN_valid update RD_LAT cycles after the request edge.
REQ-021 Reads SHALL be fully pipelined: one read per port per cycle; pN_data_out holds its value between valid pulses.
REQ-022 pN_read=1 together with pN_write=1 SHALL be ignored on that port and SHALL set err.
REQ-023 If both ports write the same address in one cycle, port 0 data SHALL be stored, port 1 SHALL be dropped, and collision SHALL pulse for 1 cycle.
REQ-024 A read and a write to the same address in the same cycle, on either port, SHALL return the old data unless MEM_WR_BYPASS_EN is defined (see Configuration).
REQ-025 Addresses SHALL be used modulo DEPTH; there is no out-of-range behaviour.
REQ-026 Requests presented while busy is high SHALL produce no write, no valid pulse and no err.

Reset
REQ-027 Asserting rst_n low SHALL immediately force the following:
- pN_data_out = 0 and pN_valid = 0;
- collision = 0 and err = 0;
- busy = 1 and state = INIT;
- the init counter = 0;
- read pipeline stages cleared.
REQ-028 A reset during INIT or READY SHALL abort any in-flight reads with no valid pulse, and SHALL restart the clear from address 0.
REQ-029 Memory contents SHALL NOT be reset asynchronously; they are defined only by the INIT clear.

Configuration
REQ-030 When macro MEM_WR_BYPASS_EN is defined, a same-cycle same-address read SHALL return the data written that cycle; after a collision, that is port 0's data.
REQ-031 When MEM_WR_BYPASS_EN is undefined, that read SHALL return the pre-write contents, with no bypass logic present.

Structure
REQ-032 Package mem_dp_pkg SHALL hold:
- the state enum typedef (INIT, READY);
- the RD_LAT legal-value constants;
- the default DATA_W and DEPTH constants.
REQ-033 Sub-module mem_rd_pipe, parameterised by DATA_W and RD_LAT, SHALL implement the per-port read data/valid delay line; it is instantiated once per port.

Verification
REQ-034 Release reset; hold p0_read=1 at addr 0 -> busy high for 32 cycles, no p0_valid during that time, then the first read returns 0x00.
REQ-035 Write 0xA5 to addr 3 on p0, then read addr 3 on p1 with RD_LAT=2 -> p1_valid pulses 2 cycles after the read, with p1_data_out=0xA5.
REQ-036 In one cycle, p0 writes 0x11 and p1 writes 0x22, both to addr 7 -> collision pulses 1 cycle, and a later read of addr 7 returns 0x11.
REQ-037 With addr 5 holding 0x00, in one cycle p0 writes 0x3C to addr 5 and p1 reads addr 5 -> p1_data_out=0x00 without the macro, or 0x3C with MEM_WR_BYPASS_EN.
REQ-038 Drive p1_read=1 and p1_write=1 together -> no write, no valid, err=1 and sticky; asserting rst_n low clears err.
REQ-039 Pulse rst_n low at cycle 10 of INIT -> busy stays high for a further 32 cycles from release, and a pending read produces no valid pulse.
